frida_seq_gen: RTL and testbench

FRIDA_SEQ_GEN -- requirements
Module: frida_seq_gen

---
 rtl/frida_seq_gen.sv | 154 +++++++++++++++
 tb/tb_frida_seq_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/frida_seq_gen.sv
// frida_seq_gen: phase sequencer for a SAR ADC array.
// Drives the init/sample/compare/logic phase clocks, collects one comparator
// decision per LOGIC phase (MSB first) and publishes the right-aligned result
// with a one-cycle done pulse. All outputs come straight from flops.
module frida_seq_gen #(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_init_cycles,
  input  logic [3:0]       cfg_samp_cycles,
  input  logic [3:0]       cfg_num_bits,
  input  logic             comp_in,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SAMP  = 3'd2,
    ST_COMP  = 3'd3,
    ST_LOGIC = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;        // remaining cycles of INIT/SAMP, minus one
  logic [3:0]       samp_q, samp_d;      // latched sample duration
  logic [4:0]       nbits_q, nbits_d;    // latched bit count, 1..16
  logic [4:0]       bits_q, bits_d;      // bits captured so far
  logic [RES_W-1:0] shift_q, shift_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [RES_W-1:0] shift_in_s;

  logic seq_init_q, seq_samp_q, seq_cmp_q, seq_logic_q, busy_q, done_q;

  assign seq_init  = seq_init_q;
  assign seq_samp  = seq_samp_q;
  assign seq_cmp   = seq_cmp_q;
  assign seq_logic = seq_logic_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

  // Shift register with the new comparator decision appended at the LSB.
  assign shift_in_s = (shift_q << 1) | {{(RES_W-1){1'b0}}, comp_in};

  // Next-state and datapath decode; abort overrides any transition outside IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    samp_d   = samp_q;
    nbits_d  = nbits_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          cnt_d   = (cfg_init_cycles == 4'd0) ? 4'd0 : (cfg_init_cycles - 4'd1);
          samp_d  = cfg_samp_cycles;
          nbits_d = (cfg_num_bits == 4'd0) ? 5'd16 : {1'b0, cfg_num_bits};
          bits_d  = 5'd0;
          shift_d = {RES_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMP;
          cnt_d   = (samp_q == 4'd0) ? 4'd0 : (samp_q - 4'd1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_COMP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_COMP: begin
        state_d = ST_LOGIC;
      end
      ST_LOGIC: begin
        shift_d = shift_in_s;
        bits_d  = bits_q + 5'd1;
        if ((bits_q + 5'd1) == nbits_q) begin
          state_d  = ST_DONE;
          result_d = shift_in_s;
        end else begin
          state_d = ST_COMP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, datapath and output flops; outputs decode the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      samp_q      <= 4'd0;
      nbits_q     <= 5'd0;
      bits_q      <= 5'd0;
      shift_q     <= {RES_W{1'b0}};
      result_q    <= {RES_W{1'b0}};
      seq_init_q  <= 1'b0;
      seq_samp_q  <= 1'b0;
      seq_cmp_q   <= 1'b0;
      seq_logic_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      nbits_q     <= nbits_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      result_q    <= result_d;
      seq_init_q  <= (state_d == ST_INIT);
      seq_samp_q  <= (state_d == ST_SAMP);
      seq_cmp_q   <= (state_d == ST_COMP);
      seq_logic_q <= (state_d == ST_LOGIC);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_frida_seq_gen.sv
// Self-checking bench for frida_seq_gen: directed scenarios plus random
// configurations, compared cycle by cycle against a timeline model.
module tb_frida_seq_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, comp_in;
  logic [3:0]  cfg_init_cycles, cfg_samp_cycles, cfg_num_bits;
  logic        seq_init, seq_samp, seq_cmp, seq_logic, busy, done;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] prev_result;

  frida_seq_gen #(.RES_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_init_cycles(cfg_init_cycles), .cfg_samp_cycles(cfg_samp_cycles),
    .cfg_num_bits(cfg_num_bits), .comp_in(comp_in),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_cmp(seq_cmp),
    .seq_logic(seq_logic), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {init,samp,cmp,logic,busy,done} for cycle k after the start cycle.
  function automatic logic [5:0] exp_ctrl(input int k, input int i, input int s, input int n);
    if (k <= i)                  return 6'b100010;
    else if (k <= i + s)         return 6'b010010;
    else if (k <= i + s + 2 * n) return (((k - i - s - 1) % 2) == 0) ? 6'b001010 : 6'b000110;
    else if (k == i + s + 2 * n + 1) return 6'b000011;
    else                         return 6'b000000;
  endfunction

  // Runs one conversion starting at the current negedge.
  // kind: 0 normal, 1 abort, 2 reset, asserted during cycle kill_at (0 = random).
  task automatic do_conv(input int ci, input int cs, input int cn, input logic [15:0] pat,
                         input bit hold, input int kind, input int kill_at);
    int i, s, n, d, last;
    int exp_res;
    logic [5:0] ctrl;
    i = (ci == 0) ? 1 : ci;
    s = (cs == 0) ? 1 : cs;
    n = (cn == 0) ? 16 : cn;
    d = 1 + i + s + 2 * n;
    exp_res = 0;
    for (int j = 0; j < n; j++) exp_res = exp_res * 2 + int'(pat[j]);
    if (kind != 0 && kill_at <= 0) kill_at = $urandom_range(1, d - 1);
    last = (kind != 0) ? kill_at + 1 : d + 1;

    start = 1'b1;
    cfg_init_cycles = 4'(ci);
    cfg_samp_cycles = 4'(cs);
    cfg_num_bits    = 4'(cn);

    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      ctrl = {seq_init, seq_samp, seq_cmp, seq_logic, busy, done};
      check("onehot", 32'($countones({seq_init, seq_samp, seq_cmp, seq_logic}) <= 1), 32'd1);
      if (kind != 0 && k == kill_at + 1) begin
        check("kill_ctrl", 32'(ctrl), 32'd0);
        if (kind == 2) prev_result = 16'h0000;
        check("kill_result", 32'(result), 32'(prev_result));
      end else begin
        check($sformatf("ctrl_k%0d", k), 32'(ctrl), 32'(exp_ctrl(k, i, s, n)));
        check($sformatf("result_k%0d", k), 32'(result), (k >= d) ? 32'(exp_res) : 32'(prev_result));
      end
      // drive inputs for cycle k
      if (!hold) start = 1'b0;
      cfg_init_cycles = 4'($urandom_range(0, 15));
      cfg_samp_cycles = 4'($urandom_range(0, 15));
      cfg_num_bits    = 4'($urandom_range(0, 15));
      if (k > i + s && k <= i + s + 2 * n && ((k - i - s) % 2) == 0)
        comp_in = pat[(k - i - s) / 2 - 1];
      else
        comp_in = 1'($urandom_range(0, 1));
      abort = 1'b0;
      rst   = 1'b0;
      if (kind == 1 && k == kill_at) abort = 1'b1;
      if (kind == 2 && k == kill_at) rst = 1'b1;
      if (kind == 0 && k == last) abort = 1'($urandom_range(0, 1));
    end
    if (kind == 0) prev_result = 16'(exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; comp_in = 1'b0;
    cfg_init_cycles = 4'd0; cfg_samp_cycles = 4'd0; cfg_num_bits = 4'd0;
    prev_result = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 32'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done}), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;

    // pattern 1,0,1,1 -> 0x000B, done in cycle 12
    do_conv(1, 2, 4, 16'h000D, 1'b0, 0, 0);
    check("dir_b", 32'(result), 32'h0000_000B);
    // all-zero config: I=1,S=1,N=16, done in cycle 35
    do_conv(0, 0, 0, 16'hFFFF, 1'b0, 0, 0);
    check("dir_ffff", 32'(result), 32'h0000_FFFF);
    // abort in the third COMP cycle (I=2,S=1 -> k=8)
    do_conv(2, 1, 5, 16'h0015, 1'b0, 1, 8);
    // back-to-back with start held, cfg scrambled mid-run
    do_conv(3, 1, 3, 16'h0005, 1'b1, 0, 0);
    do_conv(1, 4, 2, 16'h0002, 1'b1, 0, 0);
    do_conv(2, 2, 6, 16'h0029, 1'b0, 0, 0);
    // reset during SAMP (I=2,S=3 -> k=4), then a normal run
    do_conv(2, 3, 4, 16'h0007, 1'b0, 2, 4);
    do_conv(1, 1, 1, 16'h0001, 1'b0, 0, 0);

    // random configurations
    for (int r = 0; r < 30; r++) begin
      do_conv($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              16'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 1 : 0, 0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("final_idle", 32'({seq_init, seq_samp, seq_cmp, seq_logic, busy, done}), 32'd0);
    check("final_result", 32'(result), 32'(prev_result));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
